// File: rtl/data_mem_arbiter.sv
// Round-robin two-port front end for the single-port, registered-read data_mem.
// Each access walks IDLE -> ISSUE -> CAPTURE -> RESP; out-of-range addresses get an error response.
module data_mem_arbiter #(
  parameter int W     = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [W-1:0]  req0_wdata,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [W-1:0]  req1_wdata,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [W-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  // One extra bit so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_LIMIT = (AW + 1)'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic          owner;
  logic          last_grant;
  logic          err_q;
  logic          write_q;
  logic          grant_valid;
  logic          grant_port;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_wdata;
  logic          sel_write;
  logic          sel_oor;
  logic          owner_rsp_ready;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_port  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_port = ~last_grant;
    end else if (req1_valid) begin
      grant_port = 1'b1;
    end
  end

  assign accept          = (state == IDLE) && grant_valid;
  assign req0_ready      = accept && !grant_port;
  assign req1_ready      = accept && grant_port;
  assign sel_addr        = grant_port ? req1_addr  : req0_addr;
  assign sel_wdata       = grant_port ? req1_wdata : req0_wdata;
  assign sel_write       = grant_port ? req1_write : req0_write;
  assign sel_oor         = {1'b0, sel_addr} >= DEPTH_LIMIT;
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (owner_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The memory command is launched from registers so mem_write is glitch-free
  // and can only ever be high during the single ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant_port;
            last_grant <= grant_port;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            err_q      <= sel_oor;
            write_q    <= sel_write;
            mem_write  <= sel_write & ~sel_oor;
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
        end
        CAPTURE: begin
          rsp_rdata <= (!write_q && !err_q) ? mem_rdata : '0;
          rsp_err   <= err_q;
          if (owner) begin
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_valid <= 1'b1;
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: table of single transactions plus
// hand-written sequences for arbitration, response back-pressure and mid-ISSUE reset.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int W     = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  typedef struct {
    logic          port;
    logic          write;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  exp_rdata;
    logic          exp_err;
    int            exp_wr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [AW-1:0] req_addr [2];
  logic [W-1:0]  req_wdata [2];
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          busy;
  logic [W-1:0]  mem_model [DEPTH];
  int            compared = 0;
  int            mismatched = 0;
  int            bad_writes = 0;
  vec_t          vecs [10];

  always #5 clk = ~clk;

  data_mem_arbiter #(.W(W), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_write (req_write[0]),
    .req0_addr  (req_addr[0]),
    .req0_wdata (req_wdata[0]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_write (req_write[1]),
    .req1_addr  (req_addr[1]),
    .req1_wdata (req_wdata[1]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Single-port registered-read data_mem stand-in.
  always @(posedge clk) begin
    if (mem_write && int'(mem_addr) < DEPTH) mem_model[mem_addr] <= mem_wdata;
    mem_rdata <= (int'(mem_addr) < DEPTH) ? mem_model[mem_addr] : '0;
    if (mem_write && int'(mem_addr) >= DEPTH) bad_writes <= bad_writes + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int port, input logic valid, input logic wr,
                                input logic [AW-1:0] addr, input logic [W-1:0] wdata);
    req_valid[port] = valid;
    req_write[port] = wr;
    req_addr[port]  = addr;
    req_wdata[port] = wdata;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits at negedges until the given port sees req_ready, bounded.
  task automatic wait_ready(input int p, input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({name, " accepted"}, 32'(req_ready[p]), 32'd1);
  endtask

  // Waits at negedges until the given port sees rsp_valid; returns negedge count.
  task automatic wait_rsp(input int p, output int n, output int wr_cycles);
    n = 0;
    wr_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_write) wr_cycles++;
    end while (!rsp_valid[p] && n < 20);
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int p;
    int q;
    int n;
    int wr_cycles;
    p = int'(v.port);
    q = 1 - p;
    @(posedge clk);
    #1 apply_stimulus(p, 1'b1, v.write, v.addr, v.wdata);
    wait_ready(p, name);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    wait_rsp(p, n, wr_cycles);
    check_output({name, " latency"}, 32'(n), 32'd3);
    check_output({name, " rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    check_output({name, " err"}, 32'(rsp_err), 32'(v.exp_err));
    check_output({name, " other valid"}, 32'(rsp_valid[q]), 32'd0);
    check_output({name, " mem_write cycles"}, 32'(wr_cycles), 32'(v.exp_wr));
    @(posedge clk);
    #1;
    check_output({name, " valid dropped"}, 32'(rsp_valid[p]), 32'd0);
    check_output({name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int grants [$];
    int seen0;
    int seen1;
    int overlap;
    int n;
    int wr_cycles;
    vec_t v;

    // port, write, addr, wdata, exp_rdata, exp_err, exp_wr
    vecs[0] = '{1'b0, 1'b1, 5'd3,  16'hA5A5, 16'h0000, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b0, 5'd3,  16'h0000, 16'hA5A5, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b1, 5'd5,  16'h5A5A, 16'h0000, 1'b0, 1};
    vecs[3] = '{1'b1, 1'b0, 5'd5,  16'h0000, 16'h5A5A, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 5'd16, 16'h0000, 16'h0000, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b1, 5'd20, 16'hDEAD, 16'h0000, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b0, 5'd4,  16'h0000, 16'h0000, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b1, 5'd15, 16'hFFFF, 16'h0000, 1'b0, 1};
    vecs[8] = '{1'b1, 1'b0, 5'd15, 16'h0000, 16'hFFFF, 1'b0, 0};
    vecs[9] = '{1'b0, 1'b0, 5'd3,  16'h0000, 16'hA5A5, 1'b0, 0};

    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    req_write = 2'b00;
    req_addr[0] = '0;
    req_addr[1] = '0;
    req_wdata[0] = '0;
    req_wdata[1] = '0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    rst_n = 1'b0;
    #1;
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset mem_write", 32'(mem_write), 32'd0);
    check_output("reset mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_output("reset rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both ports request continuously from reset; grants must alternate starting at port 0.
    do_reset();
    seen0 = 0;
    seen1 = 0;
    overlap = 0;
    apply_stimulus(0, 1'b1, 1'b0, 5'd3, 16'h0);
    apply_stimulus(1, 1'b1, 1'b0, 5'd5, 16'h0);
    for (int c = 0; c < 60 && (seen0 + seen1) < 4; c++) begin
      @(negedge clk);
      if (req_ready[0] && req_ready[1]) overlap++;
      if (req_ready[0]) grants.push_back(0);
      if (req_ready[1]) grants.push_back(1);
      if (rsp_valid[0] && rsp_valid[1]) overlap++;
      if (rsp_valid[0]) begin
        seen0++;
        check_output("rr port0 rdata", 32'(rsp_rdata), 32'h0000A5A5);
      end
      if (rsp_valid[1]) begin
        seen1++;
        check_output("rr port1 rdata", 32'(rsp_rdata), 32'h00005A5A);
      end
      @(posedge clk);
      #1;
      if (grants.size() >= 4) req_valid = 2'b00;
    end
    check_output("rr grant count", 32'(grants.size()), 32'd4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      check_output($sformatf("rr grant %0d", g), 32'(grants[g]), 32'(g % 2));
    check_output("rr port0 responses", 32'(seen0), 32'd2);
    check_output("rr port1 responses", 32'(seen1), 32'd2);
    check_output("rr overlap", 32'(overlap), 32'd0);

    // Back-pressure on port 0 while port 1 waits.
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 5'd3, 16'h0);
    wait_ready(0, "hold port0");
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    apply_stimulus(1, 1'b1, 1'b0, 5'd5, 16'h0);
    wait_rsp(0, n, wr_cycles);
    check_output("hold latency", 32'(n), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("hold valid %0d", k), 32'(rsp_valid[0]), 32'd1);
      check_output($sformatf("hold rdata %0d", k), 32'(rsp_rdata), 32'h0000A5A5);
      check_output($sformatf("hold req1_ready %0d", k), 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 check_output("hold released", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    check_output("hold port1 granted", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(1, n, wr_cycles);
    check_output("hold port1 latency", 32'(n), 32'd3);
    check_output("hold port1 rdata", 32'(rsp_rdata), 32'h00005A5A);

    // Reset during ISSUE must cancel the write.
    @(posedge clk);
    #1 apply_stimulus(0, 1'b1, 1'b1, 5'd2, 16'h1234);
    wait_ready(0, "mid-reset write");
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check_output("issue mem_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async mem_write", 32'(mem_write), 32'd0);
    check_output("async busy", 32'(busy), 32'd0);
    check_output("async rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b0, 1'b0, 5'd2, 16'h0000, 16'h0000, 1'b0, 0};
    run_txn(v, "after reset read");

    check_output("out-of-range writes", 32'(bad_writes), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
